// File: rtl/soc_sysid_pkg.sv
// soc_sysid_pkg: register offsets, CTRL bit indices and STATUS limit for soc_sysid_regs
package soc_sysid_pkg;
  localparam logic [2:0] OFF_ID   = 3'd0;
  localparam logic [2:0] OFF_TS   = 3'd1;
  localparam logic [2:0] OFF_VER  = 3'd2;
  localparam logic [2:0] OFF_SCR  = 3'd3;
  localparam logic [2:0] OFF_UPLO = 3'd4;
  localparam logic [2:0] OFF_UPHI = 3'd5;
  localparam logic [2:0] OFF_CTRL = 3'd6;
  localparam logic [2:0] OFF_STAT = 3'd7;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  localparam logic [15:0] STATUS_MAX = 16'hFFFF;
  function automatic logic is_ro_off(input logic [2:0] a);
    return !(a == OFF_SCR || a == OFF_CTRL);
  endfunction
endpackage

// File: rtl/soc_sysid_rd_pipe.sv
// soc_sysid_rd_pipe: flushable {valid,data} delay line; output data holds its last valid value
module soc_sysid_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH:0] v_c;
  logic [W-1:0] d_q [DEPTH];
  logic [W-1:0] d_d [DEPTH];
  logic [W-1:0] d_c [DEPTH+1];
  always_comb begin
    v_c = {v_q, in_valid};
    v_d = v_c[DEPTH-1:0];
    d_c[0] = in_data;
    for (int i = 0; i < DEPTH; i++) d_c[i+1] = d_q[i];
    for (int i = 0; i < DEPTH; i++) d_d[i] = v_c[i] ? d_c[i] : d_q[i];
  end
  always_ff @(posedge clock) begin
    v_q <= reset ? '0 : v_d;
    for (int i = 0; i < DEPTH; i++) d_q[i] <= reset ? '0 : d_d[i];
  end
  assign out_valid = v_c[DEPTH];
  assign out_data  = d_c[DEPTH];
endmodule

// File: rtl/soc_sysid_regs.sv
// soc_sysid_regs: Avalon-MM system-ID slave with scratch, 64-bit uptime counter and pipelined reads
module soc_sysid_regs
  import soc_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0010,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);
  logic [31:0] scratch_q, scratch_d, shadow_q, shadow_d;
  logic [63:0] cnt_q, cnt_d;
  logic en_q, en_d, wr_ctrl;
  logic [15:0] stat_q, stat_d;
  logic [31:0] regs [8];
  always_comb begin
    wr_ctrl = write && address == OFF_CTRL;
    for (int i = 0; i < 4; i++)
      scratch_d[8*i+:8] = write && address == OFF_SCR && byteenable[i] ? writedata[8*i+:8] : scratch_q[8*i+:8];
    en_d = wr_ctrl ? writedata[CTRL_EN] : en_q;
    cnt_d = wr_ctrl && writedata[CTRL_CLR] ? '0 : cnt_q + 64'(en_q);
    shadow_d = read && address == OFF_UPLO ? cnt_q[63:32] : shadow_q;
    stat_d = write && is_ro_off(address) && stat_q != STATUS_MAX ? stat_q + 16'd1 : stat_q;
    regs[OFF_ID]   = SYSTEM_ID;
    regs[OFF_TS]   = TIMESTAMP;
    regs[OFF_VER]  = VERSION;
    regs[OFF_SCR]  = scratch_q;
    regs[OFF_UPLO] = cnt_q[31:0];
    regs[OFF_UPHI] = shadow_q;
    regs[OFF_CTRL] = {31'd0, en_q};
    regs[OFF_STAT] = {16'd0, stat_q};
  end
  always_ff @(posedge clock) begin
    scratch_q <= reset ? SCRATCH_RST : scratch_d;
    cnt_q     <= reset ? '0 : cnt_d;
    shadow_q  <= reset ? '0 : shadow_d;
    en_q      <= reset ? 1'b1 : en_d;
    stat_q    <= reset ? '0 : stat_d;
  end
  soc_sysid_rd_pipe #(.DEPTH(READ_LATENCY), .W(32)) u_rd_pipe (
    .clock(clock),
    .reset(reset),
    .in_valid(read),
    .in_data(regs[address]),
    .out_valid(readdatavalid),
    .out_data(readdata)
  );
endmodule

// File: tb/tb_soc_sysid_regs.sv
// tb_soc_sysid_regs: directed scoreboard bench for soc_sysid_regs at read latency 1 and 3
module tb_soc_sysid_regs;
  import soc_sysid_pkg::*;
  localparam logic [31:0] TS = 32'h5F5E_1000;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  logic clock = 0, reset = 1, read = 0, write = 0;
  logic [2:0] address = '0;
  logic [31:0] writedata = '0;
  logic [3:0] byteenable = '0;
  logic [31:0] readdata, readdata3;
  logic readdatavalid, readdatavalid3;
  int checks = 0, failures = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic seen;
  always #5 clock = ~clock;
  soc_sysid_regs #(.TIMESTAMP(TS)) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata), .readdatavalid(readdatavalid)
  );
  soc_sysid_regs #(.TIMESTAMP(TS), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata3), .readdatavalid(readdatavalid3)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] v, input string tag);
    address = a;
    read = 1;
    exp_q.push_back('{tag, v});
    @(negedge clock);
    read = 0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a;
    writedata = d;
    byteenable = be;
    write = 1;
    @(negedge clock);
    write = 0;
  endtask
  task automatic rst();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask
  always @(negedge clock)
    if (readdatavalid) begin
      if (exp_q.size() == 0) chk("spurious_rdv", 64'(readdatavalid), 64'd0);
      else begin
        cur = exp_q.pop_front();
        chk(cur.tag, 64'(readdata), 64'(cur.v));
      end
    end
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_rdv", 64'(readdatavalid), 64'd0);
    chk("rst_rdata", 64'(readdata), 64'd0);
    reset = 0;
    rd(OFF_ID, 32'h10, "id");
    rd(OFF_TS, TS, "timestamp");
    rd(OFF_VER, 32'h0001_0000, "version");
    rd(OFF_CTRL, 32'h1, "ctrl_rst");
    rd(OFF_STAT, 32'h0, "stat_rst");
    rd(OFF_UPHI, 32'h0, "shadow_rst");
    wr(OFF_SCR, 32'hA5A5_A5A5, 4'hF);
    wr(OFF_SCR, 32'h0, 4'b0010);
    rd(OFF_SCR, 32'hA5A5_00A5, "scratch_be");
    @(negedge clock);
    rst();
    chk("rst2_rdata", 64'(readdata), 64'd0);
    chk("rst2_rdv", 64'(readdatavalid), 64'd0);
    rd(OFF_SCR, 32'h0, "scratch_rst");
    repeat (3) wr(OFF_ID, 32'h1234, 4'hF);
    rd(OFF_ID, 32'h10, "id_unchanged");
    rd(OFF_STAT, 32'h3, "stat_3");
    for (int i = 0; i < 70000; i++) wr(OFF_STAT, 32'(i), 4'hF);
    rd(OFF_STAT, 32'h0000_FFFF, "stat_sat");
    rd(OFF_SCR, 32'h0, "scratch_after_ro");
    @(negedge clock);
    rst();
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
    rd(OFF_UPLO, 32'hFFFF_FFFF, "uplo_forced");
    release dut.cnt_q;
    rd(OFF_UPHI, 32'h0, "uphi_shadow");
    rd(OFF_UPLO, 32'h0, "uplo_wrapped");
    rd(OFF_UPHI, 32'h1, "uphi_carry");
    @(negedge clock);
    rst();
    wr(OFF_CTRL, 32'h3, 4'h0);
    rd(OFF_UPLO, 32'h0, "clr_zero");
    rd(OFF_UPLO, 32'h1, "clr_counting");
    wr(OFF_CTRL, 32'h0, 4'h0);
    rd(OFF_UPLO, 32'h3, "stop_a");
    repeat (4) @(negedge clock);
    rd(OFF_UPLO, 32'h3, "stop_b");
    rd(OFF_CTRL, 32'h0, "ctrl_off");
    wr(OFF_CTRL, 32'h3, 4'h0);
    rd(OFF_CTRL, 32'h1, "ctrl_clr_reads0");
    @(negedge clock);
    rst();
    exp_q.push_back('{"id_lat1", 32'h10});
    address = OFF_ID;
    read = 1;
    @(negedge clock);
    read = 0;
    chk("lat3_c1", 64'(readdatavalid3), 64'd0);
    @(negedge clock);
    chk("lat3_c2", 64'(readdatavalid3), 64'd0);
    @(negedge clock);
    chk("lat3_valid", {31'd0, readdatavalid3, readdata3}, {31'd0, 1'b1, 32'h10});
    @(negedge clock);
    chk("lat3_pulse", 64'(readdatavalid3), 64'd0);
    exp_q.push_back('{"id_before_flush", 32'h10});
    address = OFF_ID;
    read = 1;
    @(negedge clock);
    read = 0;
    reset = 1;
    @(negedge clock);
    reset = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      seen = seen | readdatavalid3;
    end
    chk("lat3_flush", 64'(seen), 64'd0);
    wr(OFF_SCR, 32'hCAFE_F00D, 4'hF);
    address = OFF_SCR;
    writedata = 32'h1234_5678;
    byteenable = 4'hF;
    read = 1;
    write = 1;
    exp_q.push_back('{"rw_old", 32'hCAFE_F00D});
    @(negedge clock);
    read = 0;
    write = 0;
    rd(OFF_SCR, 32'h1234_5678, "rw_new");
    repeat (4) @(negedge clock);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
